// File: rtl/checkbits_seq_monitor.sv
// Sequence checker for the firmware-driven checkbits bus: it filters glitches, then verifies that
// data values between the start and end markers are strictly ascending and arrive in the expected count.
module checkbits_seq_monitor #(
    parameter int               WIDTH         = 16,
    parameter logic [WIDTH-1:0] START_MARK    = 16'hAB40,
    parameter logic [WIDTH-1:0] END_MARK      = 16'hAB51,
    parameter int               STABLE_CYCLES = 4,
    parameter int               EXP_COUNT     = 10,
    parameter int               TIMEOUT       = 250000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] checkbits,
    output logic             sample_valid,
    output logic [WIDTH-1:0] last_value,
    output logic [7:0]       value_count,
    output logic             done,
    output logic             pass,
    output logic [2:0]       fail_code,
    output logic [1:0]       dbg_state
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] STABLE_MAX   = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    EXP_CNT      = 8'(EXP_COUNT);

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_TIMEOUT  = 3'd1;
    localparam logic [2:0] FC_ORDER    = 3'd2;
    localparam logic [2:0] FC_COUNT    = 3'd3;
    localparam logic [2:0] FC_OVERFLOW = 3'd4;
    localparam logic [2:0] FC_RESTART  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_prev_sample;
    logic [SW-1:0]    r_stable_cnt;
    logic [WIDTH-1:0] r_prev_data;
    logic [TW-1:0]    r_timer;

    logic [SW-1:0]    w_stable_next;
    logic             w_accept;
    logic             w_timeout;

    // Stability counter saturates so a long-held value keeps matching but is never re-accepted.
    always_comb begin
        w_stable_next = SW'(1);
        if (checkbits == r_prev_sample) begin
            if (r_stable_cnt == STABLE_MAX) begin
                w_stable_next = STABLE_MAX;
            end else begin
                w_stable_next = r_stable_cnt + 1'b1;
            end
        end
    end

    assign w_accept  = (w_stable_next == STABLE_MAX) && (checkbits != last_value);
    assign w_timeout = (r_timer >= TIMEOUT_LAST);
    assign dbg_state = r_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev_sample <= '0;
            r_stable_cnt  <= '0;
            sample_valid  <= 1'b0;
            last_value    <= '0;
        end else if (clear) begin
            r_prev_sample <= '0;
            r_stable_cnt  <= '0;
            sample_valid  <= 1'b0;
            last_value    <= '0;
        end else begin
            r_prev_sample <= checkbits;
            r_stable_cnt  <= w_stable_next;
            sample_valid  <= w_accept;
            if (w_accept) begin
                last_value <= checkbits;
            end
        end
    end

    // The FSM consumes the registered acceptance one cycle later, so last_value holds the new value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_prev_data <= '0;
            r_timer     <= '0;
            value_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FC_NONE;
        end else if (clear) begin
            r_state     <= S_IDLE;
            r_prev_data <= '0;
            r_timer     <= '0;
            value_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FC_NONE;
        end else begin
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (r_timer != TIMEOUT_MAX) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    if (sample_valid) begin
                        if (r_state == S_IDLE) begin
                            if (last_value == START_MARK) begin
                                r_state     <= S_RUN;
                                value_count <= '0;
                            end
                        end else if (last_value == END_MARK) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            if (value_count == EXP_CNT) begin
                                pass <= 1'b1;
                            end else begin
                                fail_code <= FC_COUNT;
                            end
                        end else if (last_value == START_MARK) begin
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                            fail_code <= FC_RESTART;
                        end else if (value_count == EXP_CNT) begin
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                            fail_code <= FC_OVERFLOW;
                        end else if ((value_count != 8'd0) && (last_value <= r_prev_data)) begin
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                            fail_code <= FC_ORDER;
                        end else begin
                            r_prev_data <= last_value;
                            value_count <= value_count + 8'd1;
                        end
                    end else if (w_timeout) begin
                        r_state   <= S_DONE;
                        done      <= 1'b1;
                        fail_code <= FC_TIMEOUT;
                    end
                end
                default: begin
                    r_state <= S_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_checkbits_seq_monitor.sv
// Directed bench for checkbits_seq_monitor: golden, glitch, order, count, restart, clear,
// async reset and timeout scenarios with hand-computed expectations.
module tb_checkbits_seq_monitor;

    logic        clock;
    logic        reset;
    logic        clear;
    logic [15:0] checkbits;
    logic        sample_valid;
    logic [15:0] last_value;
    logic [7:0]  value_count;
    logic        done;
    logic        pass;
    logic [2:0]  fail_code;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    logic [15:0] golden [10] = '{16'd40, 16'd893, 16'd2541, 16'd2669, 16'd3233,
                                 16'd4267, 16'd4622, 16'd5681, 16'd6023, 16'd9073};

    checkbits_seq_monitor #(
        .TIMEOUT(1000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .checkbits   (checkbits),
        .sample_valid(sample_valid),
        .last_value  (last_value),
        .value_count (value_count),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .dbg_state   (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and tally any acceptance pulse seen there.
    task automatic step();
        @(negedge clock);
        if (sample_valid) pulses++;
    endtask

    task automatic hold(input logic [15:0] v, input int n);
        checkbits = v;
        repeat (n) step();
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        clear     = 1'b0;
        checkbits = 16'h0000;
        repeat (2) step();
        reset  = 1'b0;
        pulses = 0;
    endtask

    task automatic send_golden(input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            hold(golden[i], 10);
            if (glitch && i == 1) hold(16'h1234, 2);
        end
    endtask

    task automatic check_golden_result(input string tag);
        check({tag, "_pulses"}, 32'(pulses), 12);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_pass"}, 32'(pass), 1);
        check({tag, "_fc"}, 32'(fail_code), 0);
        check({tag, "_count"}, 32'(value_count), 10);
        check({tag, "_last"}, 32'(last_value), 32'hAB51);
    endtask

    initial begin
        bit found;
        reset     = 1'b1;
        clear     = 1'b0;
        checkbits = 16'h0000;

        apply_reset();
        check("rst_sv", 32'(sample_valid), 0);
        check("rst_last", 32'(last_value), 0);
        check("rst_count", 32'(value_count), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_fc", 32'(fail_code), 0);
        check("rst_state", 32'(dbg_state), 0);

        // Acceptance latency: held value accepted on the 4th stable sample, pulse lasts one cycle.
        checkbits = 16'hAB40;
        repeat (3) step();
        check("lat_early", 32'(sample_valid), 0);
        step();
        check("lat_accept", 32'(sample_valid), 1);
        check("lat_last", 32'(last_value), 32'hAB40);
        step();
        check("lat_end", 32'(sample_valid), 0);
        check("lat_state_run", 32'(dbg_state), 1);
        repeat (5) step();
        send_golden(10, 1'b0);
        hold(16'hAB51, 10);
        check_golden_result("golden");
        check("golden_state", 32'(dbg_state), 2);

        apply_reset();
        hold(16'hAB40, 10);
        send_golden(10, 1'b1);
        hold(16'hAB51, 10);
        check_golden_result("glitch");

        apply_reset();
        hold(16'hAB40, 10);
        send_golden(2, 1'b0);
        checkbits = 16'd500;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sample_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("order_seen", 32'(found), 1);
        check("order_done_pre", 32'(done), 0);
        step();
        check("order_done", 32'(done), 1);
        check("order_fc", 32'(fail_code), 2);
        check("order_count", 32'(value_count), 2);
        check("order_pass", 32'(pass), 0);
        hold(16'd600, 10);
        check("order_frozen_cnt", 32'(value_count), 2);
        check("order_frozen_fc", 32'(fail_code), 2);
        check("order_track_last", 32'(last_value), 600);

        apply_reset();
        hold(16'hAB40, 10);
        send_golden(9, 1'b0);
        hold(16'hAB51, 10);
        check("short_done", 32'(done), 1);
        check("short_fc", 32'(fail_code), 3);
        check("short_count", 32'(value_count), 9);
        check("short_pass", 32'(pass), 0);

        apply_reset();
        hold(16'hAB40, 10);
        send_golden(10, 1'b0);
        hold(16'd9500, 10);
        check("ovf_done", 32'(done), 1);
        check("ovf_fc", 32'(fail_code), 4);
        check("ovf_count", 32'(value_count), 10);
        hold(16'hAB51, 10);
        check("ovf_frozen_fc", 32'(fail_code), 4);
        check("ovf_frozen_pass", 32'(pass), 0);

        apply_reset();
        hold(16'hAB40, 10);
        send_golden(2, 1'b0);
        hold(16'hAB40, 10);
        check("restart_fc", 32'(fail_code), 5);
        check("restart_count", 32'(value_count), 2);
        check("restart_done", 32'(done), 1);

        apply_reset();
        hold(16'hAB40, 10);
        send_golden(5, 1'b0);
        check("clr_pre_count", 32'(value_count), 5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_count", 32'(value_count), 0);
        check("clr_last", 32'(last_value), 0);
        check("clr_sv", 32'(sample_valid), 0);
        check("clr_done", 32'(done), 0);
        check("clr_state", 32'(dbg_state), 0);
        pulses = 0;
        hold(16'hAB40, 10);
        send_golden(10, 1'b0);
        hold(16'hAB51, 10);
        check_golden_result("clr_rerun");

        apply_reset();
        hold(16'hAB40, 10);
        send_golden(4, 1'b0);
        check("arst_pre_count", 32'(value_count), 4);
        #2 reset = 1'b1;
        #1;
        check("arst_count", 32'(value_count), 0);
        check("arst_last", 32'(last_value), 0);
        check("arst_state", 32'(dbg_state), 0);
        check("arst_done", 32'(done), 0);
        repeat (2) step();
        reset = 1'b0;

        apply_reset();
        repeat (999) step();
        check("to_early", 32'(done), 0);
        step();
        check("to_done", 32'(done), 1);
        check("to_fc", 32'(fail_code), 1);
        check("to_pass", 32'(pass), 0);
        hold(16'hAB40, 10);
        check("to_ignore_state", 32'(dbg_state), 2);
        check("to_ignore_fc", 32'(fail_code), 1);
        check("to_ignore_count", 32'(value_count), 0);
        check("to_track_last", 32'(last_value), 32'hAB40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/checkbits_seq_monitor.md
Name: checkbits_seq_monitor

Overview:
Synthesizable sequence checker that sits directly downstream of the 16-bit checkbits field (mprj_io[31:16]) driven by firmware in the LA/qsort tests.
- Filters glitches on the bus and detects the start marker.
- Verifies that the data values following the start marker arrive in strictly ascending order, with the expected count, before the end marker.
- Reports pass/fail with a failure code, and times out if the sequence stalls.

Parameters:
WIDTH, 16, checkbits width
START_MARK, 16'hAB40, start-of-test marker
END_MARK, 16'hAB51, end-of-test marker
STABLE_CYCLES, 4, consecutive identical samples required to accept a value (>=1)
EXP_COUNT, 10, number of data values expected between markers (1..255)
TIMEOUT, 250000, cycles from reset/clear to forced timeout failure

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous restart; returns FSM to IDLE and zeroes all status
checkbits  input  WIDTH  observed GPIO value
sample_valid  output  1  one-cycle pulse when a new value is accepted
last_value  output  WIDTH  most recently accepted value
value_count  output  8  data values accepted in RUN (markers excluded)
done  output  1  sequence finished (pass or fail); held until clear/reset
pass  output  1  high with done when the sequence was correct
fail_code  output  3  0 none, 1 timeout, 2 order, 3 count, 4 overflow, 5 restart

Behaviour:
- Reset (async) and clear (sync) set every output to 0, the FSM to IDLE, the stability counter to 0, the timeout counter to 0, and the internal candidate/accepted registers to 0. Priority is reset > clear > everything else.
- Stability filter:
  - Register the previous sample.
  - If checkbits equals the previous sample, the stability counter increments (saturating); otherwise it resets to 1.
  - A value is accepted on the cycle the counter reaches STABLE_CYCLES and the value differs from last_value.
  - Acceptance raises sample_valid for exactly one cycle and updates last_value in that same cycle.
  - Latency: acceptance occurs STABLE_CYCLES cycles after the bus settles.
  - Repeated identical values are never re-accepted, so duplicates are invisible by design.
- FSM states: IDLE, RUN, DONE.
  - IDLE: an accepted START_MARK moves the FSM to RUN with value_count=0. All other accepted values are ignored.
  - RUN, on each accepted value v:
    - v==END_MARK: go to DONE. pass=1 if value_count==EXP_COUNT, else fail_code=3.
    - v==START_MARK: DONE, fail_code=5.
    - value_count==EXP_COUNT (a further data value arrives): DONE, fail_code=4.
    - value_count>0 and v <= previous data value (unsigned): DONE, fail_code=2. value_count is not incremented.
    - Otherwise: store v as the previous data value and increment value_count.
  - DONE: done=1. Outputs are frozen, except sample_valid and last_value, which continue to track the filter. Exit only via clear or reset.
- Timeout:
  - The counter increments every cycle while in IDLE or RUN.
  - On reaching TIMEOUT it forces DONE with fail_code=1.
  - If timeout and an acceptance occur in the same cycle, the acceptance is evaluated and timeout is ignored.
  - The counter does not run in DONE.
- The first data value in RUN is never an order failure; its only lower bound is the START_MARK transition.
- pass and a nonzero fail_code are mutually exclusive. done=1 whenever either is set.
- Internal counters are sized to hold TIMEOUT and STABLE_CYCLES without wrap.

Test Plan:
- Golden sequence: AB40, 40, 893, 2541, 2669, 3233, 4267, 4622, 5681, 6023, 9073, AB51, each held 10 cycles -> 12 sample_valid pulses; done=1, pass=1, fail_code=0, value_count=10, last_value=AB51.
- Glitch rejection: within the golden run, a 2-cycle value 0x1234 is inserted between 893 and 2541 -> no acceptance of 0x1234; same result as golden.
- Order error: AB40, 40, 893, 500 -> done=1 one cycle after 500 is accepted; fail_code=2, value_count=2, pass=0.
- Count errors:
  - Only 9 values then AB51 -> fail_code=3.
  - 11 ascending values -> fail_code=4 on the 11th, value_count=10.
- Timeout: TIMEOUT=1000, bus held at 0 -> done=1 with fail_code=1 exactly 1000 cycles after reset release; a subsequent AB40 is ignored.
- Reset and clear mid-run:
  - Assert clear after 5 values -> all outputs 0, FSM in IDLE; a fresh golden sequence then passes.
  - Asynchronous reset pulsed mid-cycle -> outputs 0 immediately, without waiting for a clock edge.
